vga_layer_compositor: RTL

//   Parametrised, pipelined pixel compositor for the VGA path. Combines NUM_LAYERS

---
 rtl/vga_layer_compositor_if.sv | 48 ++++
 rtl/vga_layer_compositor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_compositor_if.sv
// Pixel/overlay bundle between the overlay generators, the compositor and the VGA pins.
// Latency: none (wires only).
// Backpressure: none; one pixel per clock, pix_vld qualifies each beat.
//
// Signals:
//   frame_start              one-cycle pulse at the start of each frame
//   pix_vld                  coordinates/hits valid this cycle
//   horz_coord/vert_coord    pixel x/y
//   layer_hit                bit i = pixel lies inside overlay layer i
//   axis_on/tick_on/grid_on  background feature enables
//   cfg_we/cfg_addr/cfg_dat  layer config write {EN, MODE[1:0], COLOUR}
//   pix_vld_out              pix_vld delayed two cycles
//   red/green/blue           composited pixel
interface vga_layer_compositor_if #(
    parameter int NUM_LAYERS = 16,
    parameter int CH_W       = 4,
    parameter int COORD_W    = 12
);
    logic                  frame_start;
    logic                  pix_vld;
    logic [COORD_W-1:0]    horz_coord;
    logic [COORD_W-1:0]    vert_coord;
    logic [NUM_LAYERS-1:0] layer_hit;
    logic                  axis_on;
    logic                  tick_on;
    logic                  grid_on;
    logic                  cfg_we;
    logic [4:0]            cfg_addr;
    logic [3*CH_W+2:0]     cfg_dat;
    logic                  pix_vld_out;
    logic [CH_W-1:0]       red;
    logic [CH_W-1:0]       green;
    logic [CH_W-1:0]       blue;

    // master: pixel source / config host side
    modport master (
        output frame_start, pix_vld, horz_coord, vert_coord, layer_hit,
               axis_on, tick_on, grid_on, cfg_we, cfg_addr, cfg_dat,
        input  pix_vld_out, red, green, blue
    );

    // slave: the compositor
    modport slave (
        input  frame_start, pix_vld, horz_coord, vert_coord, layer_hit,
               axis_on, tick_on, grid_on, cfg_we, cfg_addr, cfg_dat,
        output pix_vld_out, red, green, blue
    );
endinterface

// File: rtl/vga_layer_compositor.sv
// Priority compositor: NUM_LAYERS overlay layers (layer 0 on top) over an axis/tick/grid background.
// Latency: 2 cycles, fully pipelined, one pixel per clock.
// Backpressure: none; never stalls, pix_vld_out simply follows pix_vld.
//
// Ports:
//   clk_i    pixel clock
//   rst_ni   asynchronous active-low reset
//   bus_if   vga_layer_compositor_if.slave (pixel in, layer config, RGB out)
module vga_layer_compositor #(
    parameter int NUM_LAYERS   = 16,
    parameter int CH_W         = 4,
    parameter int COORD_W      = 12,
    parameter int AXIS_X       = 640,
    parameter int AXIS_Y       = 512,
    parameter int GRID_X       = 80,
    parameter int GRID_Y       = 64,
    parameter int TICK_X       = 20,
    parameter int TICK_Y       = 16,
    parameter int TICK_HALF_X  = 10,   // vertical half-length of ticks on the x-axis
    parameter int TICK_HALF_Y  = 6,    // horizontal half-length of ticks on the y-axis
    parameter int BLINK_FRAMES = 30
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    vga_layer_compositor_if.slave  bus_if
);
    localparam int PIX_W = 3 * CH_W;
    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CH_W-1:0]    CH_MAX = '1;
    localparam logic [CH_W-1:0]    CH_0   = '0;
    // tick green is 9/15 of full scale (0x9 at 4 bits)
    localparam logic [CH_W-1:0]    TICK_G = CH_W'((9 * ((1 << CH_W) - 1)) / 15);
    localparam logic [COORD_W-1:0] AX     = COORD_W'(AXIS_X);
    localparam logic [COORD_W-1:0] AY     = COORD_W'(AXIS_Y);

    // ---------------- layer configuration ----------------
    logic [NUM_LAYERS-1:0] en_q;
    logic [1:0]            mode_q [NUM_LAYERS];
    logic [PIX_W-1:0]      col_q  [NUM_LAYERS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                mode_q[i] <= '0;
                col_q[i]  <= '0;
            end
        end else if (bus_if.cfg_we && (int'(bus_if.cfg_addr) < NUM_LAYERS)) begin
            en_q[bus_if.cfg_addr[IDX_W-1:0]]   <= bus_if.cfg_dat[PIX_W+2];
            mode_q[bus_if.cfg_addr[IDX_W-1:0]] <= bus_if.cfg_dat[PIX_W+1 -: 2];
            col_q[bus_if.cfg_addr[IDX_W-1:0]]  <= bus_if.cfg_dat[PIX_W-1:0];
        end
    end

    // ---------------- frame-stepped animation state ----------------
    logic [CH_W-1:0] rb_k_q, rb_k_d;
    logic [2:0]      rb_p_q, rb_p_d;
    logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_on_q, blink_on_d;

    always_comb begin
        rb_k_d      = rb_k_q;
        rb_p_d      = rb_p_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (bus_if.frame_start) begin
            rb_k_d = rb_k_q + 1'b1;
            // phase advances when the ramp wraps from max back to 0
            if (rb_k_q == CH_MAX) begin
                rb_p_d = (rb_p_q == 3'd5) ? 3'd0 : rb_p_q + 3'd1;
            end
            if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rb_k_q      <= '0;
            rb_p_q      <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            rb_k_q      <= rb_k_d;
            rb_p_q      <= rb_p_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    // ---------------- stage 1: background and winning layer ----------------
    logic [COORD_W-1:0]    px, py, dx, dy;
    logic                  is_axis, is_tick, is_grid;
    logic [NUM_LAYERS-1:0] eff_hit;
    logic                  s1_vld_q, s1_vld_d;
    logic                  s1_hit_q, s1_hit_d;
    logic [IDX_W-1:0]      s1_win_q, s1_win_d;
    logic [PIX_W-1:0]      s1_bg_q,  s1_bg_d;

    assign px = bus_if.horz_coord;
    assign py = bus_if.vert_coord;
    assign dx = (px >= AX) ? px - AX : AX - px;
    assign dy = (py >= AY) ? py - AY : AY - py;

    assign is_axis = (px == AX) || (py == AY);
    assign is_tick = ((dy < COORD_W'(TICK_HALF_X)) && ((px % COORD_W'(TICK_X)) == '0)) ||
                     ((dx < COORD_W'(TICK_HALF_Y)) && ((py % COORD_W'(TICK_Y)) == '0));
    assign is_grid = ((px % COORD_W'(GRID_X)) == '0) || ((py % COORD_W'(GRID_Y)) == '0);

    always_comb begin
        s1_vld_d = bus_if.pix_vld;
        if (bus_if.axis_on && is_axis) begin
            s1_bg_d = {CH_MAX, CH_0, CH_0};
        end else if (bus_if.tick_on && is_tick) begin
            s1_bg_d = {CH_0, TICK_G, CH_MAX};
        end else if (bus_if.grid_on && is_grid) begin
            s1_bg_d = {CH_0, CH_MAX, CH_0};
        end else begin
            s1_bg_d = '0;
        end

        // a blink-mode layer is transparent during the off half-period,
        // so lower layers win in its place
        eff_hit = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            eff_hit[i] = bus_if.layer_hit[i] & en_q[i] &
                         ~((mode_q[i] == 2'd2) & ~blink_on_q);
        end
        s1_win_d = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eff_hit[i]) begin
                s1_win_d = IDX_W'(i);
            end
        end
        s1_hit_d = |eff_hit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld_q <= 1'b0;
            s1_hit_q <= 1'b0;
            s1_win_q <= '0;
            s1_bg_q  <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_hit_q <= s1_hit_d;
            s1_win_q <= s1_win_d;
            s1_bg_q  <= s1_bg_d;
        end
    end

    // ---------------- stage 2: colour resolve ----------------
    // Mode and colour are looked up here rather than carried from stage 1,
    // so a config write lands on whichever stage reads it next.
    logic [PIX_W-1:0] lay_col, rainbow, blend;
    logic [1:0]       lay_mode;
    logic [CH_W:0]    blend_sum;
    logic             out_vld_q, out_vld_d;
    logic [PIX_W-1:0] out_pix_q, out_pix_d;

    always_comb begin
        lay_col  = col_q[s1_win_q];
        lay_mode = mode_q[s1_win_q];

        case (rb_p_q)
            3'd0:    rainbow = {CH_MAX, rb_k_q, CH_0};
            3'd1:    rainbow = {CH_MAX - rb_k_q, CH_MAX, CH_0};
            3'd2:    rainbow = {CH_0, CH_MAX, rb_k_q};
            3'd3:    rainbow = {CH_0, CH_MAX - rb_k_q, CH_MAX};
            3'd4:    rainbow = {rb_k_q, CH_0, CH_MAX};
            default: rainbow = {CH_MAX, CH_0, CH_MAX - rb_k_q};
        endcase

        blend     = '0;
        blend_sum = '0;
        for (int c = 0; c < 3; c++) begin
            blend_sum = {1'b0, lay_col[c*CH_W +: CH_W]} + {1'b0, s1_bg_q[c*CH_W +: CH_W]};
            blend[c*CH_W +: CH_W] = blend_sum[CH_W:1];
        end

        out_vld_d = s1_vld_q;
        if (!s1_vld_q) begin
            out_pix_d = '0;
        end else if (!s1_hit_q) begin
            out_pix_d = s1_bg_q;
        end else begin
            case (lay_mode)
                2'd1:    out_pix_d = rainbow;
                2'd3:    out_pix_d = blend;
                default: out_pix_d = lay_col;   // solid, or blink while visible
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld_q <= 1'b0;
            out_pix_q <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_pix_q <= out_pix_d;
        end
    end

    assign bus_if.pix_vld_out = out_vld_q;
    assign bus_if.red         = out_pix_q[3*CH_W-1 -: CH_W];
    assign bus_if.green       = out_pix_q[2*CH_W-1 -: CH_W];
    assign bus_if.blue        = out_pix_q[CH_W-1:0];
endmodule
